// File: rtl/screen_controller.sv
// Battle Tank game-flow FSM and final VGA pixel multiplexer.
// Screen select updates only on frame ticks so screen changes never tear mid-frame.
module screen_controller #(
  parameter int unsigned VIDEO_DELAY     = 2,
  parameter int unsigned WIN_HOLD_FRAMES = 180
) (
  input  logic        pClk,
  input  logic        pReset,
  input  logic        pVideo_on,
  input  logic        pFrame_tick,
  input  logic        pStart,
  input  logic        pTank1_hit,
  input  logic        pTank2_hit,
  input  logic [11:0] pTitle_rgb,
  input  logic [11:0] pGame_rgb,
  input  logic [11:0] pP1win_rgb,
  input  logic [11:0] pP2win_rgb,
  output logic [11:0] pVga_rgb,
  output logic [1:0]  pState,
  output logic        pGame_active
);

  typedef enum logic [1:0] {
    StTitle = 2'd0,
    StPlay  = 2'd1,
    StP1Win = 2'd2,
    StP2Win = 2'd3
  } state_e;

  localparam logic [7:0] HoldMax = 8'(WIN_HOLD_FRAMES);

  state_e      r_state;
  state_e      w_state_next;
  logic        r_start_prev;
  logic        w_start_edge;
  logic [7:0]  r_hold;
  logic        w_hold_done;
  logic        w_in_win;
  logic [1:0]  r_sel;
  logic        r_game_active;
  logic        w_vid_d;
  logic [11:0] w_pix;
  logic [11:0] r_rgb;

  assign w_start_edge = pStart & ~r_start_prev;
  assign w_in_win     = (r_state == StP1Win) || (r_state == StP2Win);
  assign w_hold_done  = (r_hold == HoldMax);

  // start_prev resets high so a button held through reset needs a fresh press.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      r_start_prev <= 1'b1;
    end else begin
      r_start_prev <= pStart;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StTitle: begin
        if (w_start_edge) w_state_next = StPlay;
      end
      StPlay: begin
        if (pTank1_hit && pTank2_hit) begin
          w_state_next = StTitle;
        end else if (pTank2_hit) begin
          w_state_next = StP1Win;
        end else if (pTank1_hit) begin
          w_state_next = StP2Win;
        end
      end
      StP1Win, StP2Win: begin
        if (w_hold_done && w_start_edge) w_state_next = StTitle;
      end
      default: w_state_next = StTitle;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (pReset) begin
      r_state       <= StTitle;
      r_game_active <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_game_active <= (w_state_next == StPlay);
    end
  end

  // Held at zero outside win states, so it is already clear on entry.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      r_hold <= 8'd0;
    end else if (!w_in_win) begin
      r_hold <= 8'd0;
    end else if (pFrame_tick && !w_hold_done) begin
      r_hold <= r_hold + 8'd1;
    end
  end

  // Loads the pre-transition state when a transition coincides with a tick.
  always_ff @(posedge pClk) begin
    if (pReset) begin
      r_sel <= 2'd0;
    end else if (pFrame_tick) begin
      r_sel <= r_state;
    end
  end

  generate
    if (VIDEO_DELAY == 0) begin : g_no_delay
      assign w_vid_d = pVideo_on;
    end else begin : g_delay
      logic [VIDEO_DELAY-1:0] r_vid;
      always_ff @(posedge pClk) begin
        if (pReset) begin
          r_vid <= '0;
        end else begin
          r_vid[0] <= pVideo_on;
          for (int i = 1; i < int'(VIDEO_DELAY); i++) begin
            r_vid[i] <= r_vid[i-1];
          end
        end
      end
      assign w_vid_d = r_vid[VIDEO_DELAY-1];
    end
  endgenerate

  always_comb begin
    w_pix = 12'h000;
    unique case (r_sel)
      2'd0: w_pix = pTitle_rgb;
      2'd1: w_pix = pGame_rgb;
      2'd2: w_pix = pP1win_rgb;
      2'd3: w_pix = pP2win_rgb;
      default: w_pix = 12'h000;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (pReset) begin
      r_rgb <= 12'h000;
    end else begin
      r_rgb <= w_vid_d ? w_pix : 12'h000;
    end
  end

  assign pVga_rgb     = r_rgb;
  assign pState       = r_state;
  assign pGame_active = r_game_active;

endmodule
